// File: rtl/control_pipe_pkg.sv
// Shared constants and types for the decode-to-execute control pipe.
// Opcodes, ALU/writeback codes and the registered control bundle.
package control_pipe_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MULD = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_PASS   = 5'd10,
      ALU_MUL    = 5'd11,
      ALU_MULH   = 5'd12,
      ALU_MULHSU = 5'd13,
      ALU_MULHU  = 5'd14,
      ALU_DIV    = 5'd15,
      ALU_DIVU   = 5'd16,
      ALU_REM    = 5'd17,
      ALU_REMU   = 5'd18
   } alu_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC  = 2'd2
   } wb_e;

   typedef struct packed {
      logic       pcsel;
      logic       immsel;
      logic       regwren;
      logic       rs1sel;
      logic       rs2sel;
      logic       memren;
      logic       memwren;
      wb_e        wbsel;
      alu_e       alusel;
      logic [2:0] brfunc;
      logic       is_branch;
      logic       is_system;
   } ctrl_t;

   // alt picks SUB on funct3=000 and SRA on funct3=101
   function automatic alu_e alu_base(input logic [2:0] f3,
                                     input logic       alt);
      alu_e r;
      r = ALU_ADD;
      case (f3)
         3'b000: r = alt ? ALU_SUB : ALU_ADD;
         3'b001: r = ALU_SLL;
         3'b010: r = ALU_SLT;
         3'b011: r = ALU_SLTU;
         3'b100: r = ALU_XOR;
         3'b101: r = alt ? ALU_SRA : ALU_SRL;
         3'b110: r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/control_pipe_decode.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle,
// illegal flag, register indices and source-usage flags.
module ctrl_decode
   import control_pipe_pkg::*;
#(
   parameter bit SUPPORT_M = 1'b0
) (
   input  logic [31:0] insn_i,
   output ctrl_t       ctrl_o,
   output logic        illegal_o,
   output logic        uses_rs1_o,
   output logic        uses_rs2_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o
);

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   ctrl_t      c;
   logic       ill;
   logic       u1;
   logic       u2;

   assign op = insn_i[6:0];
   assign f3 = insn_i[14:12];
   assign f7 = insn_i[31:25];

   always_comb begin
      c        = '0;
      c.alusel = ALU_ADD;
      c.wbsel  = WB_ALU;
      ill      = 1'b0;
      u1       = 1'b0;
      u2       = 1'b0;
      unique case (op)
         OP_REG: begin
            u1        = 1'b1;
            u2        = 1'b1;
            c.regwren = 1'b1;
            if (f7 == F7_BASE)
               c.alusel = alu_base(f3, 1'b0);
            else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
               c.alusel = alu_base(f3, 1'b1);
            else if (f7 == F7_MULD && SUPPORT_M)
               c.alusel = alu_e'(5'(ALU_MUL) + {2'b00, f3});
            else
               ill = 1'b1;
         end
         OP_IMM: begin
            u1        = 1'b1;
            c.regwren = 1'b1;
            c.immsel  = 1'b1;
            c.rs2sel  = 1'b1;
            if (f3 == 3'b001) begin
               if (f7 == F7_BASE) c.alusel = ALU_SLL;
               else               ill = 1'b1;
            end else if (f3 == 3'b101) begin
               if (f7 == F7_BASE)     c.alusel = ALU_SRL;
               else if (f7 == F7_ALT) c.alusel = ALU_SRA;
               else                   ill = 1'b1;
            end else begin
               c.alusel = alu_base(f3, 1'b0);
            end
         end
         OP_LOAD: begin
            u1        = 1'b1;
            c.regwren = 1'b1;
            c.immsel  = 1'b1;
            c.rs2sel  = 1'b1;
            c.memren  = 1'b1;
            c.wbsel   = WB_MEM;
            ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OP_STORE: begin
            u1        = 1'b1;
            u2        = 1'b1;
            c.immsel  = 1'b1;
            c.rs2sel  = 1'b1;
            c.memwren = 1'b1;
            ill = f3[2] || (f3 == 3'b011);
         end
         OP_BRANCH: begin
            u1          = 1'b1;
            u2          = 1'b1;
            c.is_branch = 1'b1;
            c.brfunc    = f3;
            c.immsel    = 1'b1;
            c.rs1sel    = 1'b1;
            c.rs2sel    = 1'b1;
            ill = (f3[2:1] == 2'b01);
         end
         OP_JAL, OP_JALR: begin
            c.pcsel   = 1'b1;
            c.regwren = 1'b1;
            c.immsel  = 1'b1;
            c.rs1sel  = (op == OP_JAL);
            c.rs2sel  = 1'b1;
            c.wbsel   = WB_PC;
            u1  = (op == OP_JALR);
            ill = (op == OP_JALR) && (f3 != 3'b000);
         end
         OP_LUI: begin
            c.regwren = 1'b1;
            c.immsel  = 1'b1;
            c.rs2sel  = 1'b1;
            c.alusel  = ALU_PASS;
         end
         OP_AUIPC: begin
            c.regwren = 1'b1;
            c.immsel  = 1'b1;
            c.rs1sel  = 1'b1;
            c.rs2sel  = 1'b1;
         end
         OP_FENCE: begin
         end
         OP_SYSTEM: c.is_system = 1'b1;
         default:   ill = 1'b1;
      endcase
      // an illegal word must not touch architectural state
      if (ill) begin
         c.regwren = 1'b0;
         c.memren  = 1'b0;
         c.memwren = 1'b0;
         c.pcsel   = 1'b0;
         u1        = 1'b0;
         u2        = 1'b0;
      end
   end

   assign ctrl_o     = c;
   assign illegal_o  = ill;
   assign uses_rs1_o = u1;
   assign uses_rs2_o = u2;
   assign rd_o       = c.regwren ? insn_i[11:7] : 5'd0;
   assign rs1_o      = insn_i[19:15];
   assign rs2_o      = insn_i[24:20];

endmodule

// File: rtl/control_pipe.sv
// ID/EX control register with valid/ready handshake, load-use bubble,
// flush and a saturating bubble counter.
module control_pipe
   import control_pipe_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter bit SUPPORT_M = 1'b0,
   parameter int CNTW      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DWIDTH-1:0] insn_i,
   input  logic [DWIDTH-1:0] pc_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DWIDTH-1:0] pc_o,
   output logic [4:0]        rd_o,
   output logic [4:0]        rs1_o,
   output logic [4:0]        rs2_o,
   output ctrl_t             ctrl_o,
   output logic              illegal_o,
   output logic [CNTW-1:0]   stall_cnt_o
);

   ctrl_t       dec_ctrl;
   logic        dec_ill;
   logic        dec_u1;
   logic        dec_u2;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;

   logic              valid_q, valid_d;
   logic [DWIDTH-1:0] pc_q, pc_d;
   logic [4:0]        rd_q, rd_d;
   logic [4:0]        rs1_q, rs1_d;
   logic [4:0]        rs2_q, rs2_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic              ill_q, ill_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;

   logic stall;
   logic in_ready;

   ctrl_decode #(
      .SUPPORT_M(SUPPORT_M)
   ) u_dec (
      .insn_i    (insn_i[31:0]),
      .ctrl_o    (dec_ctrl),
      .illegal_o (dec_ill),
      .uses_rs1_o(dec_u1),
      .uses_rs2_o(dec_u2),
      .rd_o      (dec_rd),
      .rs1_o     (dec_rs1),
      .rs2_o     (dec_rs2)
   );

   // load in the register feeds a source of the incoming instruction
   assign stall = valid_q && ctrl_q.memren && (rd_q != 5'd0) &&
                  in_valid_i &&
                  ((dec_u1 && dec_rs1 == rd_q) ||
                   (dec_u2 && dec_rs2 == rd_q));

   assign in_ready = flush_i || ((!valid_q || out_ready_i) && !stall);

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      ctrl_d  = ctrl_q;
      ill_d   = ill_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (in_valid_i && in_ready) begin
         valid_d = 1'b1;
         pc_d    = pc_i;
         rd_d    = dec_rd;
         rs1_d   = dec_rs1;
         rs2_d   = dec_rs2;
         ctrl_d  = dec_ctrl;
         ill_d   = dec_ill;
      end else if (stall && out_ready_i) begin
         valid_d = 1'b0;
         if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         ctrl_q  <= '0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         ctrl_q  <= ctrl_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready_o  = in_ready;
   assign out_valid_o = valid_q;
   assign pc_o        = pc_q;
   assign rd_o        = rd_q;
   assign rs1_o       = rs1_q;
   assign rs2_o       = rs2_q;
   assign ctrl_o      = ctrl_q;
   assign illegal_o   = ill_q;
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: one base-ISA instance and one
// M-enabled instance with a narrow stall counter, sharing stimulus.
module tb_control_pipe;
   import control_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] insn = '0;
   logic [31:0] pc = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;

   logic        ir1, ov1, ill1;
   logic [31:0] pc1;
   logic [4:0]  rd1, rsa1, rsb1;
   ctrl_t       ctrl1;
   logic [15:0] cnt1;

   logic        ir2, ov2, ill2;
   logic [31:0] pc2;
   logic [4:0]  rd2, rsa2, rsb2;
   ctrl_t       ctrl2;
   logic [2:0]  cnt2;

   int checks = 0;
   int failures = 0;

   logic [46:0] sb_q[$];
   logic [46:0] exp_cur = '0;
   logic [46:0] mon_e;
   int          w;

   always #5 clk = ~clk;

   control_pipe #(.DWIDTH(32), .SUPPORT_M(1'b0), .CNTW(16)) u1 (
      .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(ir1),
      .insn_i(insn), .pc_i(pc), .flush_i(flush), .out_valid_o(ov1),
      .out_ready_i(out_ready), .pc_o(pc1), .rd_o(rd1), .rs1_o(rsa1),
      .rs2_o(rsb1), .ctrl_o(ctrl1), .illegal_o(ill1), .stall_cnt_o(cnt1)
   );

   control_pipe #(.DWIDTH(32), .SUPPORT_M(1'b1), .CNTW(3)) u2 (
      .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(ir2),
      .insn_i(insn), .pc_i(pc), .flush_i(flush), .out_valid_o(ov2),
      .out_ready_i(out_ready), .pc_o(pc2), .rd_o(rd2), .rs1_o(rsa2),
      .rs2_o(rsb2), .ctrl_o(ctrl2), .illegal_o(ill2), .stall_cnt_o(cnt2)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [46:0] ev(input logic [31:0] p,
                                      input logic [4:0] rd,
                                      input logic ill, input logic rw,
                                      input logic mr, input alu_e alu,
                                      input wb_e wb);
      return {p, rd, ill, rw, mr, alu, wb};
   endfunction

   function automatic logic [46:0] obs1();
      return {pc1, rd1, ill1, ctrl1.regwren, ctrl1.memren,
              ctrl1.alusel, ctrl1.wbsel};
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         if (ov1 && out_ready) begin
            if (flush) begin
               if (sb_q.size() > 0) void'(sb_q.pop_front());
            end else if (sb_q.size() == 0) begin
               check("spurious_out", 64'(1), 64'(0));
            end else begin
               mon_e = sb_q.pop_front();
               check("sb_bundle", 64'(obs1()), 64'(mon_e));
            end
         end
         if (in_valid && ir1 && !flush) sb_q.push_back(exp_cur);
      end
   end

   // call at posedge+1; returns at posedge+1 after acceptance
   task automatic send(input logic [31:0] i, input logic [31:0] p,
                       input logic [46:0] e, output int waited);
      in_valid = 1'b1;
      insn     = i;
      pc       = p;
      exp_cur  = e;
      waited   = 0;
      @(negedge clk);
      while (!ir1 && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 20) check("send_timeout", 64'(waited), 64'(0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 64'(ov1), 64'(0));
      check("rst_ctrl", 64'(ctrl1), 64'(0));
      check("rst_cnt", 64'(cnt1), 64'(0));
      check("rst_pc", 64'(pc1), 64'(0));
      @(posedge clk);
      #1;

      send(32'h002081B3, 32'h100, ev(32'h100, 3, 0, 1, 0, ALU_ADD, WB_ALU), w);
      send(32'h0000A283, 32'h104, ev(32'h104, 5, 0, 1, 1, ALU_ADD, WB_MEM), w);
      send(32'h00228333, 32'h108, ev(32'h108, 6, 0, 1, 0, ALU_ADD, WB_ALU), w);
      check("loaduse_wait", 64'(w), 64'(1));
      check("loaduse_cnt", 64'(cnt1), 64'(1));
      send(32'h0000A003, 32'h10C, ev(32'h10C, 0, 0, 1, 1, ALU_ADD, WB_MEM), w);
      send(32'h00200333, 32'h110, ev(32'h110, 6, 0, 1, 0, ALU_ADD, WB_ALU), w);
      check("x0_nostall_wait", 64'(w), 64'(0));
      check("x0_nostall_cnt", 64'(cnt1), 64'(1));
      send(32'h0000A283, 32'h114, ev(32'h114, 5, 0, 1, 1, ALU_ADD, WB_MEM), w);
      send(32'h0050A023, 32'h118, ev(32'h118, 0, 0, 0, 0, ALU_ADD, WB_ALU), w);
      check("store_rs2_wait", 64'(w), 64'(1));
      check("store_rs2_cnt", 64'(cnt1), 64'(2));

      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      send(32'h40208233, 32'h200, ev(32'h200, 4, 0, 1, 0, ALU_SUB, WB_ALU), w);
      in_valid = 1'b1;
      insn     = 32'h00500413;
      pc       = 32'h204;
      exp_cur  = ev(32'h204, 8, 0, 1, 0, ALU_ADD, WB_ALU);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("hold_ready", 64'(ir1), 64'(0));
         check("hold_pc", 64'(pc1), 64'(32'h200));
         check("hold_alu", 64'(ctrl1.alusel), 64'(ALU_SUB));
         check("hold_valid", 64'(ov1), 64'(1));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("release_ready", 64'(ir1), 64'(1));
      @(posedge clk);
      #1 in_valid = 1'b0;

      send(32'h002081B3, 32'h300, ev(32'h300, 3, 0, 1, 0, ALU_ADD, WB_ALU), w);
      in_valid = 1'b1;
      insn     = 32'h0000A283;
      pc       = 32'h304;
      flush    = 1'b1;
      @(negedge clk);
      check("flush_ready", 64'(ir1), 64'(1));
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_valid", 64'(ov1), 64'(0));
      @(posedge clk);
      #1;

      send(32'h00500413, 32'h400, ev(32'h400, 8, 0, 1, 0, ALU_ADD, WB_ALU), w);
      reset    = 1'b1;
      in_valid = 1'b1;
      insn     = 32'h002081B3;
      pc       = 32'h404;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("mrst_valid", 64'(ov1), 64'(0));
      check("mrst_ctrl", 64'(ctrl1), 64'(0));
      check("mrst_pc", 64'(pc1), 64'(0));
      check("mrst_rd", 64'(rd1), 64'(0));
      check("mrst_rs1", 64'(rsa1), 64'(0));
      check("mrst_ill", 64'(ill1), 64'(0));
      check("mrst_cnt", 64'(cnt1), 64'(0));
      check("mrst_cnt_m", 64'(cnt2), 64'(0));
      @(posedge clk);
      #1;

      send(32'h022083B3, 32'h500, ev(32'h500, 0, 1, 0, 0, ALU_ADD, WB_ALU), w);
      @(negedge clk);
      check("mul_m_valid", 64'(ov2), 64'(1));
      check("mul_m_alu", 64'(ctrl2.alusel), 64'(ALU_MUL));
      check("mul_m_ill", 64'(ill2), 64'(0));
      check("mul_m_rd", 64'(rd2), 64'(7));
      check("mul_m_wren", 64'(ctrl2.regwren), 64'(1));
      @(posedge clk);
      #1;
      send(32'h00000000, 32'h504, ev(32'h504, 0, 1, 0, 0, ALU_ADD, WB_ALU), w);
      send(32'h000000EF, 32'h508, ev(32'h508, 1, 0, 1, 0, ALU_ADD, WB_PC), w);
      send(32'h000014B7, 32'h50C, ev(32'h50C, 9, 0, 1, 0, ALU_PASS, WB_ALU), w);

      for (int k = 0; k < 9; k++) begin
         send(32'h0000A283, 32'h600 + 8 * k,
              ev(32'h600 + 8 * k, 5, 0, 1, 1, ALU_ADD, WB_MEM), w);
         send(32'h00228333, 32'h604 + 8 * k,
              ev(32'h604 + 8 * k, 6, 0, 1, 0, ALU_ADD, WB_ALU), w);
         check("loop_wait", 64'(w), 64'(1));
      end
      check("cnt_nine", 64'(cnt1), 64'(9));
      check("cnt_saturate", 64'(cnt2), 64'(7));

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 64'(sb_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Parametrised successor to the decode-stage control unit. It decodes full RV32I, plus optional M-extension, into a control bundle.
- The bundle is registered into the ID/EX pipeline register behind a valid/ready handshake.
- Adds load-use hazard detection (one-bubble insertion), flush, illegal-instruction flagging and a saturating stall counter.
- Sits between the fetch/decode datapath and the execute stage.

Parameters:
- DWIDTH, 32, instruction/PC width.
- SUPPORT_M, 0, 1 = decode MUL/DIV (funct7=7'b0000001); 0 = such encodings are illegal.
- CNTW, 16, width of stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid_i  in  1  decode-side instruction valid
- in_ready_o  out  1  block can accept instruction this cycle
- insn_i  in  DWIDTH  instruction
- pc_i  in  DWIDTH  instruction PC
- flush_i  in  1  squash register contents and current input (branch redirect)
- out_valid_o  out  1  registered bundle valid
- out_ready_i  in  1  execute stage accepts bundle
- pc_o  out  DWIDTH  registered PC
- rd_o, rs1_o, rs2_o  out  5 each  registered register indices
- ctrl_o  out  ctrl_t  registered control bundle: pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren, wbsel[1:0], alusel[4:0], brfunc[2:0], is_branch, is_system
- illegal_o  out  1  registered: instruction was illegal
- stall_cnt_o  out  CNTW  saturating count of bubble cycles

Behaviour:
- Reset (sync, active-high) clears out_valid_o, ctrl_o, illegal_o, pc_o, rd_o, rs1_o, rs2_o and stall_cnt_o to 0. The cleared ctrl_o gives alusel=ALU_ADD and wbsel=WB_ALU. Reset mid-transfer drops the in-flight instruction.
- Decode is combinational on insn_i. Defaults are all zero, alusel=ALU_ADD, wbsel=WB_ALU.
  - R-type: regwren=1; alusel per funct3 (ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND); funct7[5] selects SUB/SRA.
  - I-ALU: as R-type with immsel=1, rs2sel=1. SUB is not available. funct7[5] is used only for shifts.
  - M-ops (SUPPORT_M=1): ALU_MUL..ALU_REMU indexed by funct3.
  - LOAD: regwren, immsel, rs2sel, memren, wbsel=WB_MEM, alusel=ADD.
  - STORE: immsel, rs2sel, memwren, alusel=ADD.
  - BRANCH: is_branch=1, brfunc=funct3, immsel=1, rs1sel=1, rs2sel=1, alusel=ADD (target). Comparison is done in the branch unit.
  - JAL: pcsel, regwren, immsel, rs1sel=1, rs2sel=1, wbsel=WB_PC.
  - JALR: JAL fields with rs1sel=0; funct3 must be 0.
  - LUI: regwren, immsel, rs2sel, alusel=ALU_PASS.
  - AUIPC: regwren, immsel, rs1sel=1, rs2sel=1, alusel=ADD.
  - FENCE: no-op.
  - SYSTEM: is_system=1.
  - Any other opcode/funct combination: illegal=1, with regwren, memren, memwren and pcsel forced 0.
- Register-source usage: uses_rs1 for R, I, LOAD, STORE, BRANCH, JALR. uses_rs2 for R, STORE, BRANCH.
- Hazard: stall = out_valid_o && ctrl_o.memren && rd_o!=0 && in_valid_i && ((uses_rs1 && rs1==rd_o) || (uses_rs2 && rs2==rd_o)).
- in_ready_o = flush_i || ((!out_valid_o || out_ready_i) && !stall).
- Register update, in priority order each clk:
  1. reset
  2. flush_i: out_valid_o<=0; input is consumed and discarded.
  3. Accepted transfer (in_valid_i && in_ready_o): load bundle, out_valid_o<=1.
  4. stall && out_ready_i: load bubble (out_valid_o<=0), stall_cnt_o++ (saturating at all-ones).
  5. out_ready_i: out_valid_o<=0.
  6. Otherwise: hold all outputs.
- Latency: one cycle from accepted input to out_valid_o. Throughput: 1/cycle when not stalled.
- A stall lasts exactly one cycle. After the bubble, out_valid_o=0, so the hazard clears.
- With out_ready_i=0 and out_valid_o=1, outputs are stable. A stall while the consumer is blocked does not increment the counter.
- rd_o is recorded as 0 for instructions without regwren (STORE, BRANCH, illegal), so those never trigger a hazard.

Decomposition:
- Existing constants package gains:
  - opcodes: JALR, AUIPC, FENCE, SYSTEM
  - 5-bit ALU codes: ALU_SLT, ALU_SLTU, ALU_MUL..ALU_REMU
  - WB codes
  - ctrl_t packed struct
- One sub-module, ctrl_decode: purely combinational, insn → ctrl_t + illegal + uses_rs1/uses_rs2. control_pipe holds the handshake, hazard and counter logic.

Test Plan:
- add x3,x1,x2 (0x002081B3), in_valid=1, out_ready=1 → next cycle out_valid=1, regwren=1, alusel=ALU_ADD, rd_o=3, illegal=0.
- lw x5,0(x1) then add x6,x5,x2 back-to-back, out_ready=1 → in_ready_o=0 for one cycle, one bubble (out_valid=0), add issues next cycle, stall_cnt_o=1.
- lw x0,0(x1) then add x6,x0,x2 → no stall, stall_cnt_o stays 0.
- out_ready=0 for 3 cycles holding a sub x4,x1,x2 → ctrl_o, pc_o stable, in_ready_o=0; release → accepts next instruction same cycle.
- flush_i=1 with valid input and valid register → next cycle out_valid=0, input dropped; reset asserted same cycle → all outputs 0.
- mul x7,x1,x2 (0x022083B3) with SUPPORT_M=0 → illegal_o=1, regwren=0; with SUPPORT_M=1 → alusel=ALU_MUL, illegal_o=0; stall_cnt_o saturates at 0xFFFF with CNTW=16.
